// File: rtl/rgb_filter_pkg.sv
// rgb_filter_pkg
//   Shared widths and helpers for the 3x3 RGB convolution stage.
//   PIX_W  : unsigned pixel channel width
//   COEF_W : signed kernel coefficient width
//   PROD_W : signed width of one pixel*coef product
//   SUM_W  : signed width of the nine-product sum (cannot overflow)
//   TAPS   : window taps per channel
package rgb_filter_pkg;

  localparam int PIX_W  = 8;
  localparam int COEF_W = 8;
  localparam int PROD_W = 17;
  localparam int SUM_W  = 21;
  localparam int TAPS   = 9;

  // Saturate a signed sum into 0..255.
  function automatic logic [PIX_W-1:0] clampU8(input logic signed [SUM_W-1:0] v);
    logic [PIX_W-1:0] r;
    if (v[SUM_W-1]) begin
      r = '0;
    end else if (v[SUM_W-2:PIX_W] != '0) begin
      r = '1;
    end else begin
      r = v[PIX_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/rgb_filter_3x3_mac.sv
// filter_mac_3x3
//   One colour channel of the 3x3 convolution: nine unsigned pixels times
//   nine signed coefficients, summed, arithmetic-shifted and clamped.
//   Two register stages (products, then clamped result); no control logic,
//   the valid tag travels alongside in the parent.
//   Ports:
//     clk, reset : clock and synchronous active-high reset (clears oPix)
//     iPix       : nine 8-bit pixels, tap t at [8t+7:8t]
//     iCoef      : nine signed 8-bit coefs, coef t pairs with pixel t
//     oPix       : filtered, clamped 8-bit result
module filter_mac_3x3
  import rgb_filter_pkg::*;
#(
  parameter int shift = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [TAPS*PIX_W-1:0]    iPix,
  input  logic [TAPS*COEF_W-1:0]   iCoef,
  output logic [PIX_W-1:0]         oPix
);

  logic signed [PROD_W-1:0] prodReg [TAPS];
  logic signed [SUM_W-1:0]  sumAll;
  logic signed [SUM_W-1:0]  sumShifted;

  // Stage A: one registered product per tap. The pixel gets a zero MSB so
  // the multiply is signed throughout.
  for (genvar gi = 0; gi < TAPS; gi++) begin : prod
    logic signed [PROD_W-1:0] pixExt;
    logic signed [PROD_W-1:0] coefExt;

    assign pixExt  = PROD_W'($signed({1'b0, iPix[gi*PIX_W +: PIX_W]}));
    assign coefExt = PROD_W'($signed(iCoef[gi*COEF_W +: COEF_W]));

    always_ff @(posedge clk) begin
      prodReg[gi] <= pixExt * coefExt;
    end
  end

  // Stage B: adder tree, floor shift, clamp.
  always_comb begin
    sumAll = '0;
    for (int i = 0; i < TAPS; i++) begin
      sumAll = sumAll + SUM_W'(prodReg[i]);
    end
  end

  assign sumShifted = sumAll >>> shift;

  always_ff @(posedge clk) begin
    if (reset) begin
      oPix <= '0;
    end else begin
      oPix <= clampU8(sumShifted);
    end
  end

endmodule

// File: rtl/rgb_filter_3x3.sv
// rgb_filter_3x3
//   Spatial 3x3 convolution on a zero-padded 24-bit RGB stream. The padded
//   frame has stride width+1 and height+2 lines; the window is a delay chain
//   with taps at 0,1,2, S,S+1,S+2, 2S,2S+1,2S+2 (delay 0 = bottom-right).
//   Output for accepted input k appears exactly 3 clk later.
//   Ports:
//     clk, reset : clock, synchronous active-high reset
//     iValid     : iData holds a padded-stream pixel this cycle
//     iData      : {R,G,B}, 8-bit unsigned each
//     iCoef      : nine signed 8-bit coefs, [71:64]=top-left ... [7:0]=bottom-right;
//                  sampled when k==0 is accepted
//     oData      : filtered {R,G,B}, clamped 0..255
//     oValid     : oData valid
//     oDone      : pulse with the last oValid of a frame
module rgb_filter_3x3
  import rgb_filter_pkg::*;
#(
  parameter int width  = 320,
  parameter int height = 240,
  parameter int shift  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   iValid,
  input  logic [3*PIX_W-1:0]     iData,
  input  logic [TAPS*COEF_W-1:0] iCoef,
  output logic [3*PIX_W-1:0]     oData,
  output logic                   oValid,
  output logic                   oDone
);

  localparam int STRIDE    = width + 1;
  localparam int FRAME_LEN = STRIDE * (height + 2);
  // Each line buffer delays by STRIDE-3 accepts: RAM of STRIDE-4 entries
  // plus its registered read port, which acts as the final stage.
  localparam int LB_DEPTH  = STRIDE - 4;
  localparam int PTR_W     = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  logic [31:0]             kReg;
  logic [31:0]             colReg;
  logic [31:0]             lineReg;
  logic [3*PIX_W-1:0]      win [TAPS];
  logic [TAPS*COEF_W-1:0]  coefReg;
  logic [PTR_W-1:0]        lbPtr;
  logic                    validS1Reg, validS2Reg;
  logic                    doneS1Reg, doneS2Reg;
  logic                    centreValid;
  logic                    lastInFrame;

  // With k = line*S + col, the centre m = k-(S+1) is an active pixel exactly
  // when col>=1 (not the wrap column) and line>=2 (below the top padding).
  assign centreValid = (colReg != 32'd0) && (lineReg >= 32'd2);
  assign lastInFrame = (kReg == 32'(FRAME_LEN - 1));

  // Two line buffers: buffer 0 feeds the middle row from tap 2, buffer 1
  // feeds the top row from tap 5. Contents never need reset because valid
  // outputs only see pixels from the current frame or the zeroed window.
  for (genvar gi = 0; gi < 2; gi++) begin : lb
    logic [3*PIX_W-1:0] mem [LB_DEPTH];
    logic [3*PIX_W-1:0] rdReg;

    always_ff @(posedge clk) begin
      if (iValid && !reset) begin
        rdReg      <= mem[lbPtr];
        mem[lbPtr] <= win[3*gi + 2];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lbPtr <= '0;
    end else if (iValid) begin
      lbPtr <= (lbPtr == PTR_W'(LB_DEPTH - 1)) ? '0 : lbPtr + 1'b1;
    end
  end

  // Coefficients are held for the whole frame.
  always_ff @(posedge clk) begin
    if (iValid && !reset && (kReg == 32'd0)) begin
      coefReg <= iCoef;
    end
  end

  // Counter, window and valid/done tag pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      kReg       <= '0;
      colReg     <= '0;
      lineReg    <= '0;
      validS1Reg <= 1'b0;
      validS2Reg <= 1'b0;
      doneS1Reg  <= 1'b0;
      doneS2Reg  <= 1'b0;
      oValid     <= 1'b0;
      oDone      <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        win[i] <= '0;
      end
    end else begin
      if (iValid) begin
        win[0] <= iData;
        win[1] <= win[0];
        win[2] <= win[1];
        win[3] <= lb[0].rdReg;
        win[4] <= win[3];
        win[5] <= win[4];
        win[6] <= lb[1].rdReg;
        win[7] <= win[6];
        win[8] <= win[7];

        if (lastInFrame) begin
          kReg    <= '0;
          colReg  <= '0;
          lineReg <= '0;
        end else begin
          kReg <= kReg + 32'd1;
          if (colReg == 32'(STRIDE - 1)) begin
            colReg  <= '0;
            lineReg <= lineReg + 32'd1;
          end else begin
            colReg <= colReg + 32'd1;
          end
        end
      end

      validS1Reg <= iValid && centreValid;
      doneS1Reg  <= iValid && lastInFrame;
      validS2Reg <= validS1Reg;
      doneS2Reg  <= doneS1Reg;
      oValid     <= validS2Reg;
      oDone      <= doneS2Reg;
    end
  end

  // One MAC per colour channel; channel gi occupies bits [8gi+7:8gi].
  for (genvar gi = 0; gi < 3; gi++) begin : chan
    logic [TAPS*PIX_W-1:0] tapPix;

    for (genvar gj = 0; gj < TAPS; gj++) begin : tap
      assign tapPix[gj*PIX_W +: PIX_W] = win[gj][gi*PIX_W +: PIX_W];
    end

    filter_mac_3x3 #(.shift(shift)) mac (
      .clk   (clk),
      .reset (reset),
      .iPix  (tapPix),
      .iCoef (coefReg),
      .oPix  (oData[gi*PIX_W +: PIX_W])
    );
  end

endmodule

// File: tb/tb_rgb_filter_3x3.sv
// Directed bench for rgb_filter_3x3 with a 4x3 active image (stride 5, 25
// padded inputs per frame).
module tb_rgb_filter_3x3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        iValid = 1'b0;
  logic [23:0] iData = '0;
  logic [71:0] iCoef = '0;
  logic [23:0] oData;
  logic        oValid;
  logic        oDone;

  rgb_filter_3x3 #(.width(4), .height(3), .shift(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .iValid (iValid),
    .iData  (iData),
    .iCoef  (iCoef),
    .oData  (oData),
    .oValid (oValid),
    .oDone  (oDone)
  );

  always #5 clk = ~clk;

  localparam logic [71:0] K_ID    = 72'h00_00_00_00_10_00_00_00_00;
  localparam logic [71:0] K_GAUSS = 72'h01_02_01_02_04_02_01_02_01;
  localparam logic [71:0] K_NEG   = 72'h00_00_00_00_F0_00_00_00_00;
  localparam logic [71:0] K_SAT   = 72'h00_00_00_00_40_00_00_00_00;
  localparam logic [71:0] K_JUNK  = 72'hA5_5A_C3_3C_81_7E_99_66_F0;

  int rampExp  [12] = '{0, 10, 20, 30, 40, 50, 60, 70, 80, 90, 100, 110};
  int gaussExp [12] = '{56, 75, 75, 56, 75, 100, 100, 75, 56, 75, 75, 56};
  int zeroExp  [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int satExp   [12] = '{255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255};

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int drvCyc = 0;

  logic [23:0] capData [$];
  logic        capDone [$];
  int          capCyc  [$];
  int          doneCnt = 0;
  int          strayDone = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Output logger (no checking here).
  always @(negedge clk) begin
    if (oValid) begin
      capData.push_back(oData);
      capDone.push_back(oDone);
      capCyc.push_back(cyc);
    end
    if (oDone) doneCnt <= doneCnt + 1;
    if (oDone && !oValid) strayDone <= strayDone + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive padded inputs k=0..count-1. mode 0: ramp 10*i, mode 1: all 100.
  // iCoef carries the real kernel only at k==0 and junk otherwise.
  task automatic sendFrame(input int mode, input int gapMax, input logic [71:0] coef,
                           input int count);
    int line, col, idx, n;
    logic [7:0] pix;
    for (int k = 0; k < count; k++) begin
      if (gapMax > 0 && k > 0) begin
        n = $urandom_range(1, gapMax);
        iValid = 1'b0;
        iData  = 24'hFFFFFF;
        step(n);
      end
      line = k / 5;
      col  = k % 5;
      pix  = 8'd0;
      if (line >= 1 && line <= 3 && col < 4) begin
        idx = (line - 1) * 4 + col;
        pix = (mode == 0) ? 8'(10 * idx) : 8'd100;
      end
      iValid = 1'b1;
      iData  = {pix, pix, pix};
      iCoef  = (k == 0) ? coef : K_JUNK;
      if (k == 11) drvCyc = cyc;
      step(1);
    end
    iValid = 1'b0;
    iData  = '0;
  endtask

  task automatic checkSeg(input string tag, input int base, input int exp[12]);
    int ones;
    logic [7:0] e;
    ones = 0;
    for (int i = 0; i < 12; i++) begin
      if (base + i < capData.size()) begin
        e = exp[i][7:0];
        check($sformatf("%s px%0d", tag, i), 32'(capData[base + i]), 32'({e, e, e}));
        if (capDone[base + i]) ones++;
      end
    end
    check({tag, " doneOnLast"}, 32'((base + 11 < capDone.size()) ? capDone[base + 11] : 1'b0), 32'd1);
    check({tag, " doneCountInSeg"}, 32'(ones), 32'd1);
  endtask

  task automatic runFrame(input string tag, input int mode, input int gapMax,
                          input logic [71:0] coef, input int exp[12]);
    int base, dBase;
    base  = capData.size();
    dBase = doneCnt;
    sendFrame(mode, gapMax, coef, 25);
    step(6);
    check({tag, " count"}, 32'(capData.size() - base), 32'd12);
    check({tag, " doneCnt"}, 32'(doneCnt - dBase), 32'd1);
    checkSeg(tag, base, exp);
  endtask

  initial begin
    int base, dBase, bad;

    // Reset state
    step(3);
    check("rst oValid", 32'(oValid), 32'd0);
    check("rst oDone", 32'(oDone), 32'd0);
    check("rst oData", 32'(oData), 32'd0);
    reset = 1'b0;
    step(2);

    // Identity ramp with latency check
    base = capData.size();
    runFrame("ident", 0, 0, K_ID, rampExp);
    check("ident latency", 32'((base < capCyc.size()) ? capCyc[base] - drvCyc : -1), 32'd3);

    runFrame("gauss", 1, 0, K_GAUSS, gaussExp);
    runFrame("negclamp", 1, 0, K_NEG, zeroExp);
    runFrame("saturate", 1, 0, K_SAT, satExp);
    runFrame("gaps", 0, 5, K_ID, rampExp);

    // Back-to-back frames, new kernel at the second k=0
    base  = capData.size();
    dBase = doneCnt;
    sendFrame(0, 0, K_ID, 25);
    sendFrame(1, 0, K_GAUSS, 25);
    step(6);
    check("b2b count", 32'(capData.size() - base), 32'd24);
    check("b2b doneCnt", 32'(doneCnt - dBase), 32'd2);
    checkSeg("b2b f1", base, rampExp);
    checkSeg("b2b f2", base + 12, gaussExp);

    // Reset at k=15 (with iValid high), then a clean frame
    dBase = doneCnt;
    sendFrame(1, 0, K_GAUSS, 15);
    reset  = 1'b1;
    iValid = 1'b1;
    iData  = 24'h646464;
    step(1);
    check("abort oValid", 32'(oValid), 32'd0);
    check("abort oDone", 32'(oDone), 32'd0);
    reset  = 1'b0;
    iValid = 1'b0;
    iData  = '0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (oValid !== 1'b0 || oDone !== 1'b0) bad++;
      step(1);
    end
    check("abort quiet", 32'(bad), 32'd0);
    check("abort doneCnt", 32'(doneCnt - dBase), 32'd0);
    runFrame("clean", 0, 0, K_ID, rampExp);

    check("stray oDone", 32'(strayDone), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rgb_filter_3x3.md
Name: rgb_filter_3x3

Overview:
Spatial 3x3 convolution stage for the RGB stream, directly downstream of the boundary-padding logic that follows demosaic, and upstream of rgb2ycc.
- Consumes the zero-padded 24-bit RGB stream.
- Keeps two line buffers plus a 3x3 window per channel.
- Emits exactly width*height filtered pixels per frame with a one-cycle done pulse on the last.
- Kernel coefficients are signed, loadable per frame, and normalised by a fixed right shift.

Parameters:
width, 320, active pixels per line
height, 240, active lines per frame
shift, 4, arithmetic right shift applied to each channel sum (kernel normalisation)
latency, 3, cycles from accepting input pixel k to its output (fixed; see Behaviour)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
iValid  in  1  iData is a valid padded-stream pixel this cycle
iData  in  24  {R,G,B}, 8-bit unsigned each
iCoef  in  72  nine signed 8-bit coefs, [71:64]=top-left, row-major, [7:0]=bottom-right
oData  out  24  {R,G,B} filtered, clamped to 0..255
oValid  out  1  oData valid
oDone  out  1  one-cycle pulse coincident with the last oValid of a frame

Behaviour:
- Reset is synchronous, active-high, on clk: in-frame counter, window, pipeline valids, oValid and oDone all go to 0; oData goes to 0. Line-buffer contents are don't-care.
- Input stream format: stride S = width+1 pixels per line, (height+2) lines, so N = S*(height+2) valid inputs per frame.
  - Lines 0 and height+1 are all zero.
  - Column `width` of every line is zero.
  - The block does not check padding content.
- In-frame counter k (32-bit) counts accepted inputs 0..N-1 and advances only on iValid. On k==N-1 it returns to 0, so back-to-back frames need no gap.
- iCoef is latched into an internal register when k==0 is accepted and held for the whole frame. Changes on iCoef mid-frame have no effect.
- Window: a linear delay chain advances only on iValid. Taps at delays 0,1,2, S,S+1,S+2, 2S,2S+1,2S+2; delay 0 is the bottom-right tap, delay 2S+2 is the top-left tap.
  - Two line buffers of depth S-3 sit between the tap groups; implement as RAM or shift registers.
  - Because of the zero column, the horizontal neighbours of edge pixels read zeros across the line wrap.
- Centre index m = k-(S+1). The output is valid iff m>=0, 1<=m/S<=height, and m%S<width.
  - The first output is at k = 2S+1.
  - The last output is at k = N-1; that output asserts oDone.
- Arithmetic (per channel, same for R, G and B):
  - Each tap is 8-bit unsigned times 8-bit signed, giving a 17-bit signed product.
  - The sum of the nine products is 21-bit signed; no overflow is possible.
  - The sum is arithmetic-shifted right by `shift` (floor).
  - Result <0 becomes 0; result >255 becomes 255.
- Pipeline, free-running with a valid tag:
  - Stage 1: window register update on iValid.
  - Stage 2: products registered.
  - Stage 3: adder tree, shift and clamp registered into oData/oValid/oDone.
  - Output for input k appears exactly 3 clk after the cycle k was accepted, regardless of later iValid gaps.
- iValid gaps: gaps stall the window only, so output values are independent of the gap pattern. Cycles without iValid never produce oValid beyond already-in-flight results.
- Reset mid-frame: reset wins over every other event in the same cycle. In-flight results are discarded, with no oValid and no oDone. The next accepted input is k=0 of a new frame, and coefficients are re-latched.
- If iValid arrives while oDone is pulsing, it is k=0 of the next frame and is handled normally.

Decomposition:
- Shared package rgb_filter_pkg:
  - constants PIX_W=8, COEF_W=8, PROD_W=17, SUM_W=21, TAPS=9.
  - function for clamp-to-unsigned-8.
- Sub-module filter_mac_3x3, instantiated three times (R, G, B):
  - inputs: nine 8-bit pixels, nine signed coefs.
  - contents: registered products, registered sum/shift/clamp.
  - two pipeline stages, no control logic.
- Counter, window, line buffers and the valid/done tag pipeline live in rgb_filter_3x3.

Test Plan:
- width=4, height=3, identity kernel (centre=16, others 0, shift 4); active pixels R=G=B=10*i for i=0..11.
  - Exactly 12 oValid with oData equal to the input in raster order.
  - oDone only on the 12th.
  - First output 3 clk after k=2S+1=11.
- Gaussian 1 2 1/2 4 2/1 2 1, shift 4, all active pixels 100.
  - Interior pixels give 100.
  - Corners give 56 (900>>4).
  - Non-corner edge pixels give 75 (1200>>4).
- Centre coef -16, all pixels 100: all outputs 0 (negative clamp). Centre coef 64, pixels 100: all outputs 255 (saturation).
- Same frame as the first scenario with iValid deasserted for 1–5 random cycles between pixels: identical oData sequence, 12 outputs, single oDone.
- Two back-to-back frames (no gap), second with a different iCoef set applied at k=0.
  - Frame 1 results are unaffected by the coef change.
  - Frame 2 uses the new coefs.
  - Two oDone pulses.
- Reset asserted at k=15 of a frame, then a full clean frame: no outputs or oDone from the aborted frame; the clean frame gives the correct 12 outputs.
